branch_ctrl: RTL and testbench

Decode-stage branch controller for the MIPS pipeline. It drives the branch comparator's operands and op code, selects forwarded operands, stalls ID while operands are not yet available, and issues the PC redirect and link write. It also holds the decision across external pipeline freezes so that each branch resolves exactly once, and it keeps branch statistics counters.

---
 rtl/branch_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_branch_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// branch_ctrl: decode-stage branch resolution for the MIPS pipeline.
// Picks forwarded comparator operands, stalls ID on unresolved operands,
// drives the PC redirect / link write and keeps the decision stable across
// external freezes so each branch resolves (and is counted) exactly once.

// Per-operand hazard detect and forward select.
module branch_opsel (
  input  logic [4:0]  src,
  input  logic        used,
  input  logic [31:0] rf_data,
  input  logic        ex_regwrite,
  input  logic        ex_memtoreg,
  input  logic [4:0]  ex_writereg,
  input  logic        mem_regwrite,
  input  logic        mem_memtoreg,
  input  logic [4:0]  mem_writereg,
  input  logic [31:0] mem_aluout,
  output logic        hz,
  output logic [31:0] opnd
);
  logic nz, ex_hit, mem_hit, ex_alu_hz, ex_ld_hz, mem_ld_hz;

  // r0 is hardwired zero: never a hazard, never forwarded
  assign nz      = |src;
  assign ex_hit  = nz & ex_regwrite & (ex_writereg == src);
  assign mem_hit = nz & mem_regwrite & (mem_writereg == src);

  // ALU producer in EX clears after one cycle (then forwarded from MEM);
  // a load in EX blocks for two cycles, a load in MEM for one.
  assign ex_alu_hz = ex_hit & ~ex_memtoreg;
  assign ex_ld_hz  = ex_hit & ex_memtoreg;
  assign mem_ld_hz = mem_hit & mem_memtoreg;
  assign hz        = used & (ex_alu_hz | ex_ld_hz | mem_ld_hz);

  // only an ALU result sitting in MEM can be forwarded; WB goes through
  // the write-first register file
  assign opnd = (mem_hit & ~mem_memtoreg) ? mem_aluout : rf_data;
endmodule

module branch_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [7:0]       id_alucontrol,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [31:0]      id_pc_plus4,
  input  logic [31:0]      id_offset,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic [4:0]       ex_writereg,
  input  logic             mem_regwrite,
  input  logic             mem_memtoreg,
  input  logic [4:0]       mem_writereg,
  input  logic [31:0]      mem_aluout,
  input  logic             ext_stall,
  output logic [31:0]      cmp_a,
  output logic [31:0]      cmp_b,
  output logic [7:0]       cmp_op,
  input  logic             cmp_y,
  output logic             stall_id,
  output logic             flush_ex,
  output logic             pc_src,
  output logic [31:0]      branch_target,
  output logic             link_en,
  output logic [31:0]      link_addr,
  output logic             busy,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [7:0] EXE_BEQ_OP    = 8'b0101_0001;
  localparam logic [7:0] EXE_BNE_OP    = 8'b0101_0010;
  localparam logic [7:0] EXE_BLEZ_OP   = 8'b0101_0011;
  localparam logic [7:0] EXE_BGTZ_OP   = 8'b0101_0100;
  localparam logic [7:0] EXE_BLTZ_OP   = 8'b0100_0000;
  localparam logic [7:0] EXE_BGEZ_OP   = 8'b0100_0001;
  localparam logic [7:0] EXE_BLTZAL_OP = 8'b0100_1010;
  localparam logic [7:0] EXE_BGEZAL_OP = 8'b0100_1011;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic        taken;
    logic        link;
    logic [31:0] target;
  } hold_t;

  state_t state, state_nx;
  hold_t  hold;

  logic        v, is_br, uses_rt, is_link, is_branch, hz_stall, resolve, done_out;
  logic [31:0] target_now;

  logic [1:0][4:0]  src;
  logic [1:0][31:0] rfd, opnd;
  logic [1:0]       used, hz;

  // reset also silences the combinational outputs so an abort is immediate
  assign v = id_valid & ~rst;

  // op decode: which codes are branches, which read rt, which link
  always_comb begin
    is_br   = 1'b0;
    uses_rt = 1'b0;
    is_link = 1'b0;
    case (id_alucontrol)
      EXE_BEQ_OP, EXE_BNE_OP: begin
        is_br   = 1'b1;
        uses_rt = 1'b1;
      end
      EXE_BGTZ_OP, EXE_BLEZ_OP, EXE_BLTZ_OP, EXE_BGEZ_OP: is_br = 1'b1;
      EXE_BLTZAL_OP, EXE_BGEZAL_OP: begin
        is_br   = 1'b1;
        is_link = 1'b1;
      end
      default: ;
    endcase
  end

  assign is_branch = v & is_br;

  // operand 0 = rs, operand 1 = rt
  assign src  = {id_rt, id_rs};
  assign rfd  = {rt_data, rs_data};
  assign used = {is_branch & uses_rt, is_branch};

  generate
    for (genvar k = 0; k < 2; k++) begin : g_op
      branch_opsel u_sel (
        .src          (src[k]),
        .used         (used[k]),
        .rf_data      (rfd[k]),
        .ex_regwrite  (ex_regwrite),
        .ex_memtoreg  (ex_memtoreg),
        .ex_writereg  (ex_writereg),
        .mem_regwrite (mem_regwrite),
        .mem_memtoreg (mem_memtoreg),
        .mem_writereg (mem_writereg),
        .mem_aluout   (mem_aluout),
        .hz           (hz[k]),
        .opnd         (opnd[k])
      );
    end
  endgenerate

  assign hz_stall   = is_branch & (|hz);
  assign resolve    = is_branch & ~hz_stall & ((state == IDLE) | (state == WAIT));
  assign target_now = id_pc_plus4 + id_offset;
  assign done_out   = v & (state == DONE);

  assign cmp_a    = v ? opnd[0] : 32'd0;
  assign cmp_b    = v ? opnd[1] : 32'd0;
  assign cmp_op   = v ? id_alucontrol : 8'd0;
  assign stall_id = hz_stall;
  assign flush_ex = hz_stall;
  assign busy     = (state != IDLE);

  // redirect: live comparator result when resolving, held decision in DONE
  always_comb begin
    pc_src        = 1'b0;
    link_en       = 1'b0;
    branch_target = v ? target_now : 32'd0;
    link_addr     = v ? (id_pc_plus4 + 32'd4) : 32'd0;
    if (resolve) begin
      pc_src  = cmp_y;
      link_en = is_link;
    end else if (done_out) begin
      pc_src        = hold.taken;
      link_en       = hold.link;
      branch_target = hold.target;
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state: DONE parks a resolved branch while the pipe is frozen
  always_comb begin
    state_nx = IDLE;
    if (v) begin
      case (state)
        IDLE, WAIT: begin
          if (hz_stall)                    state_nx = WAIT;
          else if (resolve && ext_stall)   state_nx = DONE;
          else                             state_nx = IDLE;
        end
        DONE:    state_nx = ext_stall ? DONE : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // capture the decision in the resolution cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          hold <= '0;
    else if (resolve) hold <= '{taken: cmp_y, link: is_link, target: target_now};
  end

  // statistics; DONE cycles never recount
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
      stall_cnt  <= '0;
    end else begin
      if (resolve)          branch_cnt <= branch_cnt + CNT_W'(1);
      if (resolve && cmp_y) taken_cnt  <= taken_cnt + CNT_W'(1);
      if (hz_stall)         stall_cnt  <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: each task pushes the expected output
// vector for a cycle, then pops and compares it once the cycle settles.
module tb_branch_ctrl;
  localparam logic [7:0] BEQ    = 8'b0101_0001;
  localparam logic [7:0] BNE    = 8'b0101_0010;
  localparam logic [7:0] BLEZ   = 8'b0101_0011;
  localparam logic [7:0] BGTZ   = 8'b0101_0100;
  localparam logic [7:0] BLTZ   = 8'b0100_0000;
  localparam logic [7:0] BGEZ   = 8'b0100_0001;
  localparam logic [7:0] BLTZAL = 8'b0100_1010;
  localparam logic [7:0] BGEZAL = 8'b0100_1011;

  typedef struct packed {
    logic        stall_id;
    logic        flush_ex;
    logic        pc_src;
    logic        link_en;
    logic        busy;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] tgt;
    logic [31:0] la;
  } obs_t;

  logic clk = 0, rst = 1;
  logic id_valid, ex_regwrite, ex_memtoreg, mem_regwrite, mem_memtoreg, ext_stall, cmp_y;
  logic [7:0]  id_alucontrol, cmp_op;
  logic [4:0]  id_rs, id_rt, ex_writereg, mem_writereg;
  logic [31:0] id_pc_plus4, id_offset, rs_data, rt_data, mem_aluout;
  logic [31:0] cmp_a, cmp_b, branch_target, link_addr;
  logic        stall_id, flush_ex, pc_src, link_en, busy;
  logic [31:0] branch_cnt, taken_cnt, stall_cnt;

  int   nrun = 0, nfail = 0;
  obs_t exp_q[$];
  obs_t e, o;

  always #5 clk = ~clk;

  branch_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_alucontrol(id_alucontrol),
    .id_rs(id_rs), .id_rt(id_rt), .id_pc_plus4(id_pc_plus4), .id_offset(id_offset),
    .rs_data(rs_data), .rt_data(rt_data), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_writereg(ex_writereg), .mem_regwrite(mem_regwrite),
    .mem_memtoreg(mem_memtoreg), .mem_writereg(mem_writereg), .mem_aluout(mem_aluout),
    .ext_stall(ext_stall), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_op(cmp_op), .cmp_y(cmp_y),
    .stall_id(stall_id), .flush_ex(flush_ex), .pc_src(pc_src),
    .branch_target(branch_target), .link_en(link_en), .link_addr(link_addr),
    .busy(busy), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
  );

  // external branch comparator
  always_comb begin
    case (cmp_op)
      BEQ:            cmp_y = (cmp_a == cmp_b);
      BNE:            cmp_y = (cmp_a != cmp_b);
      BGTZ:           cmp_y = ($signed(cmp_a) > 0);
      BLEZ:           cmp_y = ($signed(cmp_a) <= 0);
      BLTZ, BLTZAL:   cmp_y = ($signed(cmp_a) < 0);
      BGEZ, BGEZAL:   cmp_y = ($signed(cmp_a) >= 0);
      default:        cmp_y = 1'b0;
    endcase
  end

  function automatic obs_t sample();
    return '{stall_id: stall_id, flush_ex: flush_ex, pc_src: pc_src, link_en: link_en,
             busy: busy, op: cmp_op, a: cmp_a, b: cmp_b, tgt: branch_target, la: link_addr};
  endfunction

  function automatic obs_t mk(input logic s, p, l, b, input logic [7:0] op,
                              input logic [31:0] a, bb, t, la);
    return '{stall_id: s, flush_ex: s, pc_src: p, link_en: l, busy: b,
             op: op, a: a, b: bb, tgt: t, la: la};
  endfunction

  task automatic quiet();
    id_valid = 0; id_alucontrol = 0; id_rs = 0; id_rt = 0; id_pc_plus4 = 0; id_offset = 0;
    rs_data = 0; rt_data = 0; ex_regwrite = 0; ex_memtoreg = 0; ex_writereg = 0;
    mem_regwrite = 0; mem_memtoreg = 0; mem_writereg = 0; mem_aluout = 0; ext_stall = 0;
  endtask

  task automatic branch(input logic [7:0] op, input logic [4:0] rs, rt,
                        input logic [31:0] rsd, rtd, pc4, off);
    id_valid = 1; id_alucontrol = op; id_rs = rs; id_rt = rt;
    rs_data = rsd; rt_data = rtd; id_pc_plus4 = pc4; id_offset = off;
  endtask

  task automatic test_reset();
    quiet();
    exp_q.push_back('0);
    @(negedge clk);
    o = sample(); e = exp_q.pop_front();
    nrun++; if (o !== e) begin nfail++; $display("FAIL reset_outputs got=%h exp=%h", o, e); end
    nrun++; if ({branch_cnt, taken_cnt, stall_cnt} !== 96'd0) begin
      nfail++; $display("FAIL reset_counters got=%h exp=0", {branch_cnt, taken_cnt, stall_cnt}); end
    rst = 0;
  endtask

  task automatic test_beq_nohaz();
    @(posedge clk); #1;
    branch(BEQ, 5'd1, 5'd2, 32'h5, 32'h5, 32'h100, 32'h20);
    exp_q.push_back(mk(0, 1, 0, 0, BEQ, 32'h5, 32'h5, 32'h120, 32'h104));
    @(negedge clk);
    o = sample(); e = exp_q.pop_front();
    nrun++; if (o !== e) begin nfail++; $display("FAIL beq_resolve got=%h exp=%h", o, e); end
    @(posedge clk); #1; quiet();
    @(negedge clk);
    nrun++; if (branch_cnt !== 1 || taken_cnt !== 1 || stall_cnt !== 0) begin
      nfail++; $display("FAIL beq_counters got=%0d/%0d/%0d exp=1/1/0", branch_cnt, taken_cnt, stall_cnt); end
  endtask

  task automatic test_bne_fwd();
    @(posedge clk); #1;
    branch(BNE, 5'd1, 5'd2, 32'h3, 32'h0, 32'h180, 32'h8);
    ex_regwrite = 1; ex_writereg = 5'd2;
    exp_q.push_back(mk(1, 0, 0, 0, BNE, 32'h3, 32'h0, 32'h188, 32'h184));
    @(negedge clk);
    o = sample(); e = exp_q.pop_front();
    nrun++; if (o !== e) begin nfail++; $display("FAIL bne_stall got=%h exp=%h", o, e); end
    @(posedge clk); #1;
    ex_regwrite = 0; ex_writereg = 0;
    mem_regwrite = 1; mem_memtoreg = 0; mem_writereg = 5'd2; mem_aluout = 32'h7;
    exp_q.push_back(mk(0, 1, 0, 1, BNE, 32'h3, 32'h7, 32'h188, 32'h184));
    @(negedge clk);
    o = sample(); e = exp_q.pop_front();
    nrun++; if (o !== e) begin nfail++; $display("FAIL bne_forward got=%h exp=%h", o, e); end
    @(posedge clk); #1; quiet();
    @(negedge clk);
    nrun++; if (stall_cnt !== 1 || branch_cnt !== 2 || taken_cnt !== 2 || busy !== 0) begin
      nfail++; $display("FAIL bne_counters got=%0d/%0d/%0d busy=%b exp=2/2/1 busy=0",
                        branch_cnt, taken_cnt, stall_cnt, busy); end
  endtask

  task automatic test_bgtz_load();
    // target wraps: 0x300 + (-16)
    @(posedge clk); #1;
    branch(BGTZ, 5'd4, 5'd0, 32'h0, 32'h0, 32'h300, 32'hFFFF_FFF0);
    ex_regwrite = 1; ex_memtoreg = 1; ex_writereg = 5'd4;
    exp_q.push_back(mk(1, 0, 0, 0, BGTZ, 32'h0, 32'h0, 32'h2F0, 32'h304));
    exp_q.push_back(mk(1, 0, 0, 1, BGTZ, 32'h0, 32'h0, 32'h2F0, 32'h304));
    exp_q.push_back(mk(0, 1, 0, 1, BGTZ, 32'h9, 32'h0, 32'h2F0, 32'h304));
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        ex_regwrite = 0; ex_memtoreg = 0; ex_writereg = 0;
        mem_regwrite = 1; mem_memtoreg = 1; mem_writereg = 5'd4;
      end
      if (c == 2) begin
        mem_regwrite = 0; mem_memtoreg = 0; mem_writereg = 0; rs_data = 32'h9;
      end
      @(negedge clk);
      o = sample(); e = exp_q.pop_front();
      nrun++; if (o !== e) begin nfail++; $display("FAIL bgtz_load_c%0d got=%h exp=%h", c, o, e); end
      @(posedge clk); #1;
    end
    quiet();
    @(negedge clk);
    nrun++; if (stall_cnt !== 3 || branch_cnt !== 3 || taken_cnt !== 3) begin
      nfail++; $display("FAIL bgtz_counters got=%0d/%0d/%0d exp=3/3/3", branch_cnt, taken_cnt, stall_cnt); end
  endtask

  task automatic test_bgezal_link();
    @(posedge clk); #1;
    branch(BGEZAL, 5'd3, 5'd0, 32'h8000_0000, 32'h0, 32'h200, 32'h40);
    exp_q.push_back(mk(0, 0, 1, 0, BGEZAL, 32'h8000_0000, 32'h0, 32'h240, 32'h204));
    @(negedge clk);
    o = sample(); e = exp_q.pop_front();
    nrun++; if (o !== e) begin nfail++; $display("FAIL bgezal_link got=%h exp=%h", o, e); end
    @(posedge clk); #1; quiet();
    @(negedge clk);
    nrun++; if (branch_cnt !== 4 || taken_cnt !== 3) begin
      nfail++; $display("FAIL bgezal_counters got=%0d/%0d exp=4/3", branch_cnt, taken_cnt); end
  endtask

  task automatic test_bltz_freeze();
    @(posedge clk); #1;
    branch(BLTZ, 5'd5, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h400, 32'h10);
    exp_q.push_back(mk(0, 1, 0, 0, BLTZ, 32'hFFFF_FFFF, 32'h0, 32'h410, 32'h404));
    for (int c = 1; c < 4; c++)
      exp_q.push_back(mk(0, 1, 0, 1, BLTZ, 32'h1, 32'h0, 32'h410, 32'h404));
    for (int c = 0; c < 4; c++) begin
      ext_stall = (c < 3);
      // register file changes while frozen; the held decision must not
      if (c > 0) rs_data = 32'h1;
      @(negedge clk);
      o = sample(); e = exp_q.pop_front();
      nrun++; if (o !== e) begin nfail++; $display("FAIL bltz_freeze_c%0d got=%h exp=%h", c, o, e); end
      @(posedge clk); #1;
    end
    quiet();
    @(negedge clk);
    nrun++; if (branch_cnt !== 5 || taken_cnt !== 4 || busy !== 0) begin
      nfail++; $display("FAIL bltz_counters got=%0d/%0d busy=%b exp=5/4 busy=0", branch_cnt, taken_cnt, busy); end
  endtask

  task automatic test_rst_wait();
    @(posedge clk); #1;
    branch(BEQ, 5'd6, 5'd0, 32'h0, 32'h0, 32'h500, 32'h4);
    ex_regwrite = 1; ex_writereg = 5'd6;
    @(posedge clk); #1;
    @(negedge clk);
    nrun++; if (busy !== 1 || stall_id !== 1) begin
      nfail++; $display("FAIL rst_wait_entry got busy=%b stall=%b exp=1/1", busy, stall_id); end
    #1 rst = 1;
    #1;
    nrun++; if (busy !== 0 || stall_id !== 0 || flush_ex !== 0) begin
      nfail++; $display("FAIL rst_abort got busy=%b stall=%b flush=%b exp=0/0/0", busy, stall_id, flush_ex); end
    nrun++; if ({branch_cnt, taken_cnt, stall_cnt} !== 96'd0) begin
      nfail++; $display("FAIL rst_abort_counters got=%h exp=0", {branch_cnt, taken_cnt, stall_cnt}); end
    quiet();
    @(negedge clk); rst = 0;
  endtask

  task automatic test_reg0();
    @(posedge clk); #1;
    branch(BEQ, 5'd0, 5'd0, 32'h0, 32'h0, 32'h600, 32'h8);
    ex_regwrite = 1; ex_writereg = 5'd0;
    mem_regwrite = 1; mem_memtoreg = 0; mem_writereg = 5'd0; mem_aluout = 32'hDEAD;
    exp_q.push_back(mk(0, 1, 0, 0, BEQ, 32'h0, 32'h0, 32'h608, 32'h604));
    @(negedge clk);
    o = sample(); e = exp_q.pop_front();
    nrun++; if (o !== e) begin nfail++; $display("FAIL reg0_nohaz got=%h exp=%h", o, e); end
    @(posedge clk); #1; quiet();
    @(negedge clk);
    nrun++; if (branch_cnt !== 1 || taken_cnt !== 1 || stall_cnt !== 0) begin
      nfail++; $display("FAIL reg0_counters got=%0d/%0d/%0d exp=1/1/0", branch_cnt, taken_cnt, stall_cnt); end
    o = sample();
    nrun++; if (o !== '0) begin nfail++; $display("FAIL bubble_outputs got=%h exp=0", o); end
  endtask

  initial begin
    quiet();
    test_reset();
    test_beq_nohaz();
    test_bne_fwd();
    test_bgtz_load();
    test_bgezal_link();
    test_bltz_freeze();
    test_rst_wait();
    test_reg0();
    if (exp_q.size() != 0) begin
      nrun++; nfail++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end
endmodule
